// File: rtl/arp_cache_responder.sv
// ARP cache responder.
// Resolves next-hop IPv4 addresses to MACs from a small cache of
// (ip, mac, valid) entries. Lookups and cache writes share one sequential
// scan engine that compares a single entry per cycle.
module arp_cache_responder #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,

    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,

    input  logic        cache_write_valid,
    output logic        cache_write_ready,
    input  logic [31:0] cache_write_ip,
    input  logic [47:0] cache_write_mac,

    input  logic        clear_cache,

    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
);

    localparam int N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOOKUP     = 2'd1,
        WRITE_SCAN = 2'd2,
        RESPOND    = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
    // Scan key: lookup target during LOOKUP, entry IP during WRITE_SCAN.
    logic [31:0]             key_reg, key_next;
    logic [47:0]             wmac_reg, wmac_next;
    logic                    resp_valid_reg, resp_valid_next;
    logic                    resp_error_reg, resp_error_next;
    logic [47:0]             resp_mac_reg, resp_mac_next;

    // Entry write strobes: update mac of entry[idx], or insert at entry[wr_ptr].
    logic                    upd_we;
    logic                    new_we;

    logic [N-1:0]            valid_vec;
    logic [31:0]             ip_rd  [N];
    logic [47:0]             mac_rd [N];

    logic                    in_subnet;
    logic                    is_bcast;
    logic [31:0]             lookup_key;
    logic                    cur_match;

    // Cache storage, one slot per entry. Valid bits are reset and cleared;
    // ip/mac payloads are plain registers qualified by the valid bit.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : gen_entry
            localparam logic [ADDR_WIDTH-1:0] ENTRY_IDX = ADDR_WIDTH'(gi);
            logic        valid_reg;
            logic [31:0] ip_reg;
            logic [47:0] mac_reg;
            logic        new_hit;
            logic        upd_hit;

            assign new_hit = new_we & (wr_ptr_reg == ENTRY_IDX);
            assign upd_hit = upd_we & (idx_reg == ENTRY_IDX);

            // Valid bit: set on insert, dropped by clear_cache or reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                end else if (clear_cache) begin
                    valid_reg <= 1'b0;
                end else if (new_hit) begin
                    valid_reg <= 1'b1;
                end
            end

            // Payload: insert writes ip and mac, update rewrites only mac.
            always_ff @(posedge clk) begin
                if (new_hit) begin
                    ip_reg  <= key_reg;
                    mac_reg <= wmac_reg;
                end else if (upd_hit) begin
                    mac_reg <= wmac_reg;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign ip_rd[gi]     = ip_reg;
            assign mac_rd[gi]    = mac_reg;
        end
    endgenerate

    // Target selection for an incoming request.
    assign in_subnet  = ((arp_request_ip & subnet_mask) == (local_ip & subnet_mask));
    assign is_bcast   = (arp_request_ip == 32'hFFFF_FFFF) ||
                        (in_subnet && ((arp_request_ip | subnet_mask) == 32'hFFFF_FFFF));
    assign lookup_key = in_subnet ? arp_request_ip : gateway_ip;

    assign cur_match  = valid_vec[idx_reg] && (ip_rd[idx_reg] == key_reg);

    // Readies depend only on state and inputs; writes win over requests.
    assign cache_write_ready  = rst_n && (state_reg == IDLE) && !clear_cache;
    assign arp_request_ready  = cache_write_ready && !cache_write_valid;

    assign arp_response_valid = resp_valid_reg;
    assign arp_response_error = resp_error_reg;
    assign arp_response_mac   = resp_mac_reg;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            wr_ptr_reg     <= '0;
            key_reg        <= '0;
            wmac_reg       <= '0;
            resp_valid_reg <= 1'b0;
            resp_error_reg <= 1'b0;
            resp_mac_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            wr_ptr_reg     <= wr_ptr_next;
            key_reg        <= key_next;
            wmac_reg       <= wmac_next;
            resp_valid_reg <= resp_valid_next;
            resp_error_reg <= resp_error_next;
            resp_mac_reg   <= resp_mac_next;
        end
    end

    // Next-state logic for the shared scan engine.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        wr_ptr_next     = wr_ptr_reg;
        key_next        = key_reg;
        wmac_next       = wmac_reg;
        resp_valid_next = resp_valid_reg;
        resp_error_next = resp_error_reg;
        resp_mac_next   = resp_mac_reg;
        upd_we          = 1'b0;
        new_we          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cache_write_valid && cache_write_ready) begin
                    key_next   = cache_write_ip;
                    wmac_next  = cache_write_mac;
                    idx_next   = '0;
                    state_next = WRITE_SCAN;
                end else if (arp_request_valid && arp_request_ready) begin
                    if (is_bcast) begin
                        resp_valid_next = 1'b1;
                        resp_error_next = 1'b0;
                        resp_mac_next   = 48'hFFFF_FFFF_FFFF;
                        state_next      = RESPOND;
                    end else begin
                        key_next   = lookup_key;
                        idx_next   = '0;
                        state_next = LOOKUP;
                    end
                end
            end

            LOOKUP: begin
                if (clear_cache) begin
                    resp_valid_next = 1'b1;
                    resp_error_next = 1'b1;
                    resp_mac_next   = '0;
                    state_next      = RESPOND;
                end else if (cur_match) begin
                    resp_valid_next = 1'b1;
                    resp_error_next = 1'b0;
                    resp_mac_next   = mac_rd[idx_reg];
                    state_next      = RESPOND;
                end else if (idx_reg == LAST_IDX) begin
                    resp_valid_next = 1'b1;
                    resp_error_next = 1'b1;
                    resp_mac_next   = '0;
                    state_next      = RESPOND;
                end else begin
                    idx_next = idx_reg + IDX_ONE;
                end
            end

            WRITE_SCAN: begin
                if (clear_cache) begin
                    state_next = IDLE;
                end else if (cur_match) begin
                    upd_we     = 1'b1;
                    state_next = IDLE;
                end else if (idx_reg == LAST_IDX) begin
                    new_we      = 1'b1;
                    wr_ptr_next = wr_ptr_reg + IDX_ONE;
                    state_next  = IDLE;
                end else begin
                    idx_next = idx_reg + IDX_ONE;
                end
            end

            RESPOND: begin
                if (arp_response_ready) begin
                    resp_valid_next = 1'b0;
                    resp_error_next = 1'b0;
                    resp_mac_next   = '0;
                    state_next      = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A clear restarts replacement from entry 0.
        if (clear_cache) begin
            wr_ptr_next = '0;
        end
    end

endmodule

// File: tb/tb_arp_cache_responder.sv
// Testbench for arp_cache_responder: directed table, hand-written corner
// sequences and a randomized phase checked against a behavioural cache model.
module tb_arp_cache_responder;

    localparam int AW = 3;
    localparam int N  = 1 << AW;
    localparam logic [31:0] LOCAL = 32'hC0A8_0101;
    localparam logic [31:0] MASK  = 32'hFFFF_FF00;
    localparam logic [31:0] GW    = 32'hC0A8_01FE;
    localparam int TMO = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        cache_write_valid;
    logic        cache_write_ready;
    logic [31:0] cache_write_ip;
    logic [47:0] cache_write_mac;
    logic        clear_cache;
    logic [31:0] local_ip, gateway_ip, subnet_mask;

    always #5 clk = ~clk;

    arp_cache_responder #(.ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .arp_request_valid  (arp_request_valid),
        .arp_request_ready  (arp_request_ready),
        .arp_request_ip     (arp_request_ip),
        .arp_response_valid (arp_response_valid),
        .arp_response_ready (arp_response_ready),
        .arp_response_error (arp_response_error),
        .arp_response_mac   (arp_response_mac),
        .cache_write_valid  (cache_write_valid),
        .cache_write_ready  (cache_write_ready),
        .cache_write_ip     (cache_write_ip),
        .cache_write_mac    (cache_write_mac),
        .clear_cache        (clear_cache),
        .local_ip           (local_ip),
        .gateway_ip         (gateway_ip),
        .subnet_mask        (subnet_mask)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural cache: list of slots with round-robin replacement.
    logic        m_valid [N];
    logic [31:0] m_ip    [N];
    logic [47:0] m_mac   [N];
    int          m_ptr;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic int model_find(logic [31:0] key);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_ip[i] == key) return i;
        return -1;
    endfunction

    // Returns the cycle in which the cache accepts writes again.
    function automatic int model_write(logic [31:0] ip, logic [47:0] mac);
        int k;
        k = model_find(ip);
        if (k >= 0) begin
            m_mac[k] = mac;
            return k + 2;
        end
        m_ip[m_ptr]    = ip;
        m_mac[m_ptr]   = mac;
        m_valid[m_ptr] = 1'b1;
        m_ptr = (m_ptr + 1) % N;
        return N + 1;
    endfunction

    // Returns the cycle in which the response first appears.
    function automatic int model_request(logic [31:0] ip, output logic err, output logic [47:0] mac);
        logic in_sub;
        int   k;
        in_sub = ((ip & MASK) == (LOCAL & MASK));
        if (ip == 32'hFFFF_FFFF || (in_sub && ((ip | MASK) == 32'hFFFF_FFFF))) begin
            err = 1'b0;
            mac = 48'hFFFF_FFFF_FFFF;
            return 1;
        end
        k = model_find(in_sub ? ip : GW);
        if (k >= 0) begin
            err = 1'b0;
            mac = m_mac[k];
            return k + 2;
        end
        err = 1'b1;
        mac = '0;
        return N + 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for cache_write_ready; returns cycles elapsed.
    task automatic wait_write_ready(output int n);
        n = 0;
        #1;
        while (!cache_write_ready && n < TMO) begin
            @(negedge clk); #1; n++;
        end
        if (n >= TMO) chk("write_ready_timeout", 1, 0);
    endtask

    task automatic do_write(input logic [31:0] ip, input logic [47:0] mac, input int exp_lat);
        int n;
        int lat;
        @(negedge clk);
        cache_write_valid = 1'b1;
        cache_write_ip    = ip;
        cache_write_mac   = mac;
        wait_write_ready(n);
        @(posedge clk);
        @(negedge clk);
        cache_write_valid = 1'b0;
        lat = 1;
        #1;
        while (!cache_write_ready && lat < TMO) begin
            @(negedge clk); #1; lat++;
        end
        chk("write_latency", lat, exp_lat);
        $display("write ip=%h mac=%h ready_again_cycle=%0d", ip, mac, lat);
    endtask

    // Collects a response after acceptance: latency, payload, hold, handshake.
    task automatic finish_request(input logic exp_err, input logic [47:0] exp_mac,
                                  input int exp_lat, input int hold);
        int lat;
        logic [47:0] mac0;
        logic        err0;
        @(negedge clk);
        arp_request_valid = 1'b0;
        lat = 1;
        #1;
        while (!arp_response_valid && lat < TMO) begin
            @(negedge clk); #1; lat++;
        end
        chk("resp_latency", lat, exp_lat);
        chk("resp_error", arp_response_error, exp_err);
        chk("resp_mac", arp_response_mac, exp_mac);
        mac0 = arp_response_mac;
        err0 = arp_response_error;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            arp_request_valid = 1'b1;
            #1;
            chk("hold_valid", arp_response_valid, 1);
            chk("hold_mac", arp_response_mac, exp_mac);
            chk("hold_err", arp_response_error, exp_err);
            chk("hold_req_ready", arp_request_ready, 0);
        end
        @(negedge clk);
        arp_request_valid  = 1'b0;
        arp_response_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arp_response_ready = 1'b0;
        #1;
        chk("post_hs_valid", arp_response_valid, 0);
        chk("post_hs_req_ready", arp_request_ready, 1);
        $display("response err=%0d mac=%h cycle=%0d", err0, mac0, lat);
    endtask

    task automatic do_request(input logic [31:0] ip, input logic exp_err, input logic [47:0] exp_mac,
                              input int exp_lat, input int hold);
        int n;
        @(negedge clk);
        arp_request_valid = 1'b1;
        arp_request_ip    = ip;
        n = 0;
        #1;
        while (!arp_request_ready && n < TMO) begin
            @(negedge clk); #1; n++;
        end
        if (n >= TMO) chk("req_ready_timeout", 1, 0);
        @(posedge clk);
        $display("request ip=%h", ip);
        finish_request(exp_err, exp_mac, exp_lat, hold);
    endtask

    task automatic model_and_request(input logic [31:0] ip, input int hold);
        logic e;
        logic [47:0] m;
        int l;
        l = model_request(ip, e, m);
        do_request(ip, e, m, l, hold);
    endtask

    task automatic model_and_write(input logic [31:0] ip, input logic [47:0] mac);
        int l;
        l = model_write(ip, mac);
        do_write(ip, mac, l);
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] ip;
        logic [47:0] mac;
        logic        exp_err;
        logic [47:0] exp_mac;
        int          exp_lat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic        de;
        logic [47:0] dm;
        int          dl;
        logic [31:0] rip;
        logic [47:0] rmac;

        tbl[0] = '{1'b1, 32'hC0A8_0102, 48'h0200_0000_0002, 1'b0, 48'h0, 9};
        tbl[1] = '{1'b0, 32'hC0A8_0102, 48'h0, 1'b0, 48'h0200_0000_0002, 2};
        tbl[2] = '{1'b0, 32'h0A00_0005, 48'h0, 1'b1, 48'h0, 9};
        tbl[3] = '{1'b1, GW,            48'h0200_0000_00FE, 1'b0, 48'h0, 9};
        tbl[4] = '{1'b0, 32'h0A00_0005, 48'h0, 1'b0, 48'h0200_0000_00FE, 3};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF, 48'h0, 1'b0, 48'hFFFF_FFFF_FFFF, 1};
        tbl[6] = '{1'b0, 32'hC0A8_01FF, 48'h0, 1'b0, 48'hFFFF_FFFF_FFFF, 1};
        tbl[7] = '{1'b1, 32'hC0A8_0102, 48'h0200_0000_0022, 1'b0, 48'h0, 2};
        tbl[8] = '{1'b0, 32'hC0A8_0102, 48'h0, 1'b0, 48'h0200_0000_0022, 2};

        local_ip = LOCAL; gateway_ip = GW; subnet_mask = MASK;
        arp_request_valid = 0; arp_request_ip = 0; arp_response_ready = 0;
        cache_write_valid = 0; cache_write_ip = 0; cache_write_mac = 0;
        clear_cache = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_resp_valid", arp_response_valid, 0);
        chk("rst_resp_error", arp_response_error, 0);
        chk("rst_resp_mac", arp_response_mac, 0);
        chk("rst_req_ready", arp_request_ready, 0);
        chk("rst_wr_ready", cache_write_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_wr_ready", cache_write_ready, 1);
        chk("idle_req_ready", arp_request_ready, 1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].is_wr) begin
                void'(model_write(tbl[i].ip, tbl[i].mac));
                do_write(tbl[i].ip, tbl[i].mac, tbl[i].exp_lat);
            end else begin
                void'(model_request(tbl[i].ip, de, dm));
                do_request(tbl[i].ip, tbl[i].exp_err, tbl[i].exp_mac, tbl[i].exp_lat, 0);
            end
        end

        // Response held for 5 cycles with a pending request
        model_and_request(GW, 5);

        // Simultaneous write and request in IDLE: write goes first
        @(negedge clk);
        cache_write_valid = 1'b1; cache_write_ip = 32'hC0A8_0133; cache_write_mac = 48'h0200_0000_0133;
        arp_request_valid = 1'b1; arp_request_ip = 32'hC0A8_0133;
        #1;
        chk("both_wr_ready", cache_write_ready, 1);
        chk("both_req_ready", arp_request_ready, 0);
        dl = model_write(32'hC0A8_0133, 48'h0200_0000_0133);
        @(posedge clk);
        @(negedge clk);
        cache_write_valid = 1'b0;
        begin
            int lat;
            lat = 1;
            #1;
            while (!arp_request_ready && lat < TMO) begin
                @(negedge clk); #1; lat++;
            end
            chk("both_write_first_lat", lat, dl);
        end
        @(posedge clk);
        dl = model_request(32'hC0A8_0133, de, dm);
        finish_request(de, dm, dl, 0);

        // Clear, then fill N+1 distinct IPs to force wrap-around eviction
        @(negedge clk); clear_cache = 1'b1;
        @(negedge clk); clear_cache = 1'b0;
        model_reset();
        for (int i = 1; i <= N + 1; i++)
            model_and_write(32'hC0A8_0110 + 32'(i), 48'h0200_0000_1000 + 48'(i));
        do_request(32'hC0A8_0111, 1'b1, 48'h0, N + 1, 0);
        void'(model_request(32'hC0A8_0111, de, dm));
        for (int i = 2; i <= N + 1; i++)
            model_and_request(32'hC0A8_0110 + 32'(i), 0);
        model_and_write(32'hC0A8_0119, 48'h0200_0000_9999);
        model_and_request(32'hC0A8_0119, 0);
        model_and_write(32'hC0A8_011A, 48'h0200_0000_101A);
        do_request(32'hC0A8_0112, 1'b1, 48'h0, N + 1, 0);
        do_request(32'hC0A8_011A, 1'b0, 48'h0200_0000_101A, 3, 0);
        void'(model_request(32'hC0A8_0112, de, dm));

        // clear_cache mid-LOOKUP of an entry at slot N-1
        @(negedge clk);
        arp_request_valid = 1'b1; arp_request_ip = 32'hC0A8_0118;
        @(posedge clk);
        @(negedge clk); arp_request_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); clear_cache = 1'b1;
        @(negedge clk); clear_cache = 1'b0;
        #1;
        chk("clr_lookup_valid", arp_response_valid, 1);
        chk("clr_lookup_err", arp_response_error, 1);
        chk("clr_lookup_mac", arp_response_mac, 0);
        @(negedge clk); arp_response_ready = 1'b1;
        @(negedge clk); arp_response_ready = 1'b0;
        model_reset();
        model_and_request(32'hC0A8_0113, 0);

        // clear_cache mid-WRITE_SCAN drops the write
        @(negedge clk);
        cache_write_valid = 1'b1; cache_write_ip = 32'hC0A8_0140; cache_write_mac = 48'h0200_0000_0140;
        @(posedge clk);
        @(negedge clk); cache_write_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); clear_cache = 1'b1;
        @(negedge clk); clear_cache = 1'b0;
        #1;
        chk("clr_write_idle", cache_write_ready, 1);
        model_and_request(32'hC0A8_0140, 0);

        // Async reset mid-WRITE_SCAN
        model_and_write(32'hC0A8_0150, 48'h0200_0000_0150);
        @(negedge clk);
        cache_write_valid = 1'b1; cache_write_ip = 32'hC0A8_0151; cache_write_mac = 48'h0200_0000_0151;
        @(posedge clk);
        @(negedge clk); cache_write_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_ready", cache_write_ready, 0);
        chk("midrst_req_ready", arp_request_ready, 0);
        chk("midrst_resp_valid", arp_response_valid, 0);
        chk("midrst_resp_mac", arp_response_mac, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_and_request(32'hC0A8_0150, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: rip = 32'h0A00_0000 | 32'($urandom_range(1, 50));
                1: rip = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hC0A8_01FF;
                2: rip = GW;
                default: rip = 32'hC0A8_0100 | 32'($urandom_range(1, 14));
            endcase
            if ($urandom_range(0, 2) == 0) begin
                rmac = {16'h0200, $urandom()};
                if (rip == 32'hFFFF_FFFF || rip == 32'hC0A8_01FF) rip = GW;
                model_and_write(rip, rmac);
            end else begin
                model_and_request(rip, int'($urandom_range(0, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
